arbitro_saida: RTL and testbench

Registered round-robin arbiter for one output port of the 5-port mesh router. It takes the 5-bit request vector that the router control logic builds for that output and returns a one-hot grant vector, which the control logic turns into crossbar select and FIFO read enables. Five instances are used per router, one each for cima, baixo, esquerda, direita and core. It guarantees starvation-free, single-flit-per-grant service and never double-pops an input FIFO.

---
 rtl/roteador_pkg.sv | 40 ++++
 rtl/arbitro_saida_seletor_rr.sv | 29 ++
 rtl/arbitro_saida.sv | 92 +++++++++
 tb/tb_arbitro_saida.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/roteador_pkg.sv
// Shared router definitions: direction encoding, port count and pointer helpers
// used by the output-port arbiters.
package roteador_pkg;

    localparam int N_PORTAS = 5;

    typedef enum logic [2:0] {
        CIMA     = 3'd0,
        BAIXO    = 3'd1,
        ESQUERDA = 3'd2,
        DIREITA  = 3'd3,
        CORE     = 3'd4
    } direcao_t;

    typedef enum logic {
        OCIOSO    = 1'b0,
        CONCEDIDO = 1'b1
    } estado_t;

    // Request vectors are ordered with cima in the MSB, so bit = 4 - direction.
    function automatic logic [2:0] req_bit(input direcao_t dir);
        return 3'd4 - dir;
    endfunction

    function automatic logic [2:0] prox_ptr(input logic [2:0] i);
        return (i == 3'd0) ? 3'd4 : i - 3'd1;
    endfunction

    function automatic logic [2:0] indice_onehot(input logic [N_PORTAS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < N_PORTAS; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    localparam logic [2:0] PTR_INICIAL = req_bit(CIMA);

endpackage

// File: rtl/arbitro_saida_seletor_rr.sv
// Combinational round-robin search: scans eligible from ptr downward (mod 5)
// and returns the first hit as a one-hot winner.
module seletor_rr
    import roteador_pkg::*;
(
    input  logic [N_PORTAS-1:0] eligible,
    input  logic [2:0]          ptr,
    output logic [N_PORTAS-1:0] winner,
    output logic                found
);

    logic [2:0] idx;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so the loop reads updated values and no latch is inferred.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = (ptr > 3'd4) ? 3'd4 : ptr;
        for (int k = 0; k < N_PORTAS; k++) begin
            if (!found && eligible[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
            idx = prox_ptr(idx);
        end
    end

endmodule

// File: rtl/arbitro_saida.sv
// Registered round-robin arbiter for one router output port.
// Optional per-requester grant counters are built when ARB_GRANT_COUNT_EN is defined.
module arbitro_saida
    import roteador_pkg::*;
#(
    parameter int N_REQ = 5,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic                   en,
    input  logic                   clr_cnt,
    output logic [N_REQ-1:0]       grant,
    output logic                   grant_valid,
    output logic [2:0]             ptr,
    output logic [N_REQ*CNT_W-1:0] cnt_flat
);

    estado_t          estado, estado_next;
    logic [N_REQ-1:0] eligible, winner, grant_next;
    logic [2:0]       ptr_next;
    logic             found;

    // The requester granted now is popping its FIFO this cycle; its empty flag
    // is stale, so it must not be granted again on the very next edge.
    assign eligible = req & ~grant;

    seletor_rr u_seletor (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (winner),
        .found    (found)
    );

    always_comb begin
        grant_next  = '0;
        ptr_next    = ptr;
        estado_next = OCIOSO;
        if (en && found) begin
            grant_next  = winner;
            ptr_next    = prox_ptr(indice_onehot(winner));
            estado_next = CONCEDIDO;
        end
    end

    // NOTE: sequential state is updated only with non-blocking '<=' so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= OCIOSO;
            grant  <= '0;
            ptr    <= PTR_INICIAL;
        end else begin
            estado <= estado_next;
            grant  <= grant_next;
            ptr    <= ptr_next;
        end
    end

    assign grant_valid = (estado == CONCEDIDO);

`ifdef ARB_GRANT_COUNT_EN
    logic [CNT_W-1:0] cnt [N_REQ];

    // NOTE: the counter array is a handful of flops, not a RAM, so it takes the
    // asynchronous reset like the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (clr_cnt)
                    cnt[i] <= '0;
                else if (grant[i] && (cnt[i] != {CNT_W{1'b1}}))
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < N_REQ; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
    end
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign cnt_flat       = '0;
`endif

endmodule

// File: tb/tb_arbitro_saida.sv
// Scoreboard bench for arbitro_saida: a queue-based reference model predicts each
// registered grant; a negedge monitor pops and compares.
module tb_arbitro_saida;

    localparam int N     = 5;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req;
    logic               en;
    logic               clr_cnt;
    logic [N-1:0]       grant;
    logic               grant_valid;
    logic [2:0]         ptr;
    logic [N*CNT_W-1:0] cnt_flat;

    arbitro_saida #(.N_REQ(N), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .en          (en),
        .clr_cnt     (clr_cnt),
        .grant       (grant),
        .grant_valid (grant_valid),
        .ptr         (ptr),
        .cnt_flat    (cnt_flat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_mon = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [N-1:0]       grant;
        logic [2:0]         ptr;
        logic               valid;
        logic [N*CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];

    // Reference model: pointer as an integer, current grantee as an index (-1 idle).
    int m_ptr;
    int m_grant;
    int m_cnt [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr   = 4;
            m_grant = -1;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            q.delete();
        end else begin
            exp_t e;
            int   win;
            for (int i = 0; i < N; i++) begin
                if (clr_cnt) m_cnt[i] = 0;
                else if (m_grant == i && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
            end
            win = -1;
            if (en) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr - k + N) % N;
                    if (win < 0 && req[i] && i != m_grant) win = i;
                end
            end
            m_grant = win;
            if (win >= 0) m_ptr = (win + N - 1) % N;
            e.grant = (win >= 0) ? N'(1 << win) : '0;
            e.ptr   = 3'(m_ptr);
            e.valid = (win >= 0);
            e.cnt   = '0;
`ifdef ARB_GRANT_COUNT_EN
            for (int i = 0; i < N; i++) e.cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
`endif
            q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!rst && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_mon++;
            check("sb_grant", 64'(grant), 64'(e.grant));
            check("sb_ptr", 64'(ptr), 64'(e.ptr));
            check("sb_valid", 64'(grant_valid), 64'(e.valid));
            check("sb_cnt", 64'(cnt_flat), 64'(e.cnt));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = 5'b11111; en = 1'b1; clr_cnt = 1'b0;
        cycles(2);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_valid", 64'(grant_valid), 64'd0);
        check("rst_ptr", 64'(ptr), 64'd4);
        check("rst_cnt", 64'(cnt_flat), 64'd0);

        rst = 1'b0;
        cycles(1);
        check("first_grant", 64'(grant), 64'b10000);
        check("first_ptr", 64'(ptr), 64'd3);
        cycles(10);

        en = 1'b0; req = 5'b01000;
        cycles(4);
        check("en_off_grant", 64'(grant), 64'd0);

        en = 1'b1; req = 5'b00100;
        cycles(8);

        req = 5'b10010;
        cycles(6);

`ifdef ARB_GRANT_COUNT_EN
        req = 5'b00000; clr_cnt = 1'b1;
        cycles(1);
        clr_cnt = 1'b0; req = 5'b00001;
        cycles(10);
        check("sat_core", 64'(cnt_flat[CNT_W-1:0]), 64'(CMAX));
        for (int k = 0; k < 3 && grant[0] !== 1'b1; k++) cycles(1);
        check("core_granted", 64'(grant[0]), 64'd1);
        clr_cnt = 1'b1;
        cycles(1);
        clr_cnt = 1'b0;
        check("clr_wins", 64'(cnt_flat[CNT_W-1:0]), 64'd0);
        cycles(2);
`endif

        for (int n = 0; n < 400; n++) begin
            req     = N'($urandom);
            en      = ($urandom_range(0, 7) != 0);
            clr_cnt = ($urandom_range(0, 15) == 0);
            cycles(1);
        end
        clr_cnt = 1'b0;

        en = 1'b1; req = 5'b11111;
        for (int k = 0; k < 3 && grant_valid !== 1'b1; k++) cycles(1);
        check("pre_async_valid", 64'(grant_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("async_grant", 64'(grant), 64'd0);
        check("async_valid", 64'(grant_valid), 64'd0);
        check("async_ptr", 64'(ptr), 64'd4);
        cycles(1);
        rst = 1'b0;
        cycles(1);
        check("post_async_grant", 64'(grant), 64'b10000);
        cycles(12);

        check("sb_activity", 64'(n_mon > 100), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
